// File: rtl/convt3d_pkg.sv
// Shared types and constants for the transposed-conv overlap-add accumulator.
// Holds the FSM state encoding and the accumulator-to-output saturation helper.
package convt3d_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned DEPTH_DEF  = 256;
    localparam int unsigned WIDE_W     = 128;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        FLUSH,
        DRAIN
    } acc_state_t;

    // Operates on a sign-extended wide value so any ACC_W/DATA_W pairing fits.
    function automatic logic signed [WIDE_W-1:0] sat_to_data(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              data_w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = signed'((WIDE_W'(1) << (data_w - 1)) - WIDE_W'(1));
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/convt3d_acc_skid.sv
// Two-entry skid buffer between the synchronous-read tile buffer and the
// output handshake; the head entry drives the outputs directly from registers.
module convt3d_acc_skid
    import convt3d_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [1:0]        count
);

    localparam int unsigned ENT_W = DATA_W + ADDR_W + 1;

    logic [ENT_W-1:0] e0;
    logic [ENT_W-1:0] e1;
    logic [ENT_W-1:0] in_ent;
    logic [1:0]       cnt;
    logic             pop;

    assign in_ent    = {in_last, in_addr, in_data};
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign count     = cnt;
    assign {out_last, out_addr, out_data} = e0;

    // The producer never pushes into a full buffer; it reserves space before reading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0)
                        e0 <= in_ent;
                    else
                        e1 <= in_ent;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= in_ent;
                    end else begin
                        e0 <= e1;
                        e1 <= in_ent;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/convt3d_overlap_add_acc.sv
// Overlap-add accumulator: clears a tile buffer, RMW-accumulates scattered psums,
// then drains voxels in address order. CONVT_ACC_SAT_EN selects output saturation.
module convt3d_overlap_add_acc
    import convt3d_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] input_data,
    input  logic              last_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] output_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last_out,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    acc_state_t state;
    acc_state_t state_nx;

    logic [ADDR_W-1:0] idx;
    logic              rd_done;
    logic              beat;
    logic              beat_ok;

    logic [ACC_W-1:0]  mem [DEPTH];
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [ACC_W-1:0]  wd;
    logic [ACC_W-1:0]  rdata;

    logic              a_vld;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_psum;
    logic [ACC_W-1:0]  a_base;
    logic              b_vld;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_psum;
    logic [ACC_W-1:0]  b_base;
    logic [ACC_W-1:0]  b_sum;
    logic              w_vld;
    logic [ADDR_W-1:0] w_addr;
    logic [ACC_W-1:0]  w_data;

    logic              rd_pend;
    logic [ADDR_W-1:0] rd_pend_addr;
    logic              issue;
    logic              pop;
    logic [1:0]        skid_cnt;
    logic [2:0]        occ;
    logic [DATA_W-1:0] conv;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   if (idx == LAST_IDX) state_nx = ACCUM;
            ACCUM:   if (beat && last_in) state_nx = FLUSH;
            FLUSH:   if (!a_vld) state_nx = DRAIN;
            DRAIN:   if (pop && last_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready_in = (state == ACCUM);
        busy     = (state != IDLE);
    end

    assign beat    = valid_in && ready_in;
    assign beat_ok = beat && ({1'b0, addr_in} < DEPTH_L);

    // Shared index: clear address in CLEAR, next read address in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            rd_done <= 1'b0;
        end else begin
            if (state == CLEAR || (state == DRAIN && issue))
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            else if (state != DRAIN)
                idx <= '0;

            if (state == DRAIN && issue && idx == LAST_IDX)
                rd_done <= 1'b1;
            else if (state != DRAIN)
                rd_done <= 1'b0;
        end
    end

    always_comb begin
        we = 1'b0;
        wa = idx;
        wd = '0;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (b_vld) begin
            we = 1'b1;
            wa = b_addr;
            wd = b_sum;
        end
        re = beat_ok || issue;
        ra = beat_ok ? addr_in : idx;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        if (re)
            rdata <= mem[ra];
    end

    // The read returns pre-write data when it coincides with a write, so the
    // previous cycle's write is also kept for forwarding, behind Stage B.
    always_comb begin
        if (b_vld && b_addr == a_addr)
            a_base = b_sum;
        else if (w_vld && w_addr == a_addr)
            a_base = w_data;
        else
            a_base = rdata;
    end

    assign b_sum = b_base + {{(ACC_W - DATA_W){b_psum[DATA_W-1]}}, b_psum};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
            w_vld   <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            a_vld   <= beat_ok;
            b_vld   <= a_vld;
            w_vld   <= we;
            rd_pend <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_ok) begin
            a_addr <= addr_in;
            a_psum <= input_data;
        end
        if (a_vld) begin
            b_addr <= a_addr;
            b_base <= a_base;
            b_psum <= a_psum;
        end
        w_addr <= wa;
        w_data <= wd;
        if (issue)
            rd_pend_addr <= idx;
    end

    // A read is issued only when the skid will have room once it lands.
    assign pop   = valid_out && ready_out;
    assign occ   = {1'b0, skid_cnt} + {2'b00, rd_pend};
    assign issue = (state == DRAIN) && !rd_done &&
                   ((occ < 3'd2) || (occ == 3'd2 && pop));

`ifdef CONVT_ACC_SAT_EN
    logic signed [WIDE_W-1:0] sat_w;
    always_comb begin
        sat_w = sat_to_data(WIDE_W'(signed'(rdata)), DATA_W);
        conv  = sat_w[DATA_W-1:0];
    end
`else
    always_comb begin
        conv = rdata[DATA_W-1:0];
    end
`endif

    convt3d_acc_skid #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_pend),
        .in_data   (conv),
        .in_addr   (rd_pend_addr),
        .in_last   (rd_pend && rd_pend_addr == LAST_IDX),
        .out_valid (valid_out),
        .out_ready (ready_out),
        .out_data  (output_data),
        .out_addr  (addr_out),
        .out_last  (last_out),
        .count     (skid_cnt)
    );

endmodule

// File: tb/tb_convt3d_overlap_add_acc.sv
// Directed bench for convt3d_overlap_add_acc at DEPTH=8 with hand-computed drains.
module tb_convt3d_overlap_add_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [2:0]  addr_in = '0;
    logic [31:0] input_data = '0;
    logic        last_in = 1'b0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [31:0] output_data;
    logic [2:0]  addr_out;
    logic        last_out;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_v [8];

    always #5 clk = ~clk;

    convt3d_overlap_add_acc #(
        .DATA_W(32),
        .ACC_W (40),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .addr_in    (addr_in),
        .input_data (input_data),
        .last_in    (last_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .output_data(output_data),
        .addr_out   (addr_out),
        .last_out   (last_out),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tile(input bit pulse_mid);
        int n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            start = pulse_mid && (n == 3);
            if (ready_in) break;
        end
        start = 1'b0;
        check("clear_len", 64'(n), 64'd8);
    endtask

    task automatic send(input int a, input int d, input bit l);
        addr_in    = 3'(a);
        input_data = 32'(d);
        last_in    = l;
        valid_in   = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        if (l) check("ready_drop", 64'(ready_in), 64'd0);
    endtask

    task automatic drain(input string tag, input logic [15:0] pat, input int plen, input bit pulse);
        int          cyc = 0;
        int          got = 0;
        int          k = 0;
        bit          held = 1'b0;
        bit          seen = 1'b0;
        logic        rdy;
        logic [31:0] hd = '0;
        logic [2:0]  ha = '0;
        while (got < 8 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = pulse && (cyc == 2);
            if (held) begin
                check({tag, "_stall_valid"}, 64'(valid_out), 64'd1);
                check({tag, "_stall_data"}, 64'(output_data), 64'(hd));
                check({tag, "_stall_addr"}, 64'(addr_out), 64'(ha));
            end
            if (valid_out) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tag, "_first_lat"}, 64'(cyc), 64'd4);
                end
                rdy = pat[4'(k % plen)];
                k++;
                ready_out = rdy;
                if (rdy) begin
                    check({tag, "_data"}, 64'(output_data), 64'(exp_v[got]));
                    check({tag, "_addr"}, 64'(addr_out), 64'(got));
                    check({tag, "_last"}, 64'(last_out), 64'(got == 7));
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = output_data;
                    ha   = addr_out;
                end
            end else begin
                ready_out = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_count"}, 64'(got), 64'd8);
        @(posedge clk); #1;
        ready_out = 1'b0;
        check({tag, "_end_valid"}, 64'(valid_out), 64'd0);
        check({tag, "_end_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(output_data), 64'd0);
        check("rst_addr", 64'(addr_out), 64'd0);
        check("rst_last", 64'(last_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: basic overlap-add
        start_tile(1'b0);
        send(0, 5, 1'b0);
        send(1, 7, 1'b0);
        send(0, -2, 1'b0);
        send(7, 100, 1'b1);
        exp_v = '{32'd3, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100};
        drain("s1", 16'hFFFF, 1, 1'b0);

        // Scenario 2: same-address run of six
        start_tile(1'b0);
        for (int i = 0; i < 6; i++) send(3, 1, i == 5);
        exp_v = '{default: '0};
        exp_v[3] = 32'd6;
        drain("s2", 16'hFFFF, 1, 1'b0);

        // Interleaved addresses: write and read to the same address on one edge
        start_tile(1'b0);
        send(2, 1, 1'b0);
        send(5, 1, 1'b0);
        send(2, 1, 1'b0);
        send(5, 1, 1'b0);
        send(2, 1, 1'b1);
        exp_v = '{default: '0};
        exp_v[2] = 32'd3;
        exp_v[5] = 32'd2;
        drain("s2b", 16'hFFFF, 1, 1'b0);

        // Scenario 3: backpressure 1,0,0,1,0,1
        start_tile(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(i, i * 10 + 1, i == 7);
            exp_v[i] = 32'(i * 10 + 1);
        end
        drain("s3", 16'b10_1001, 6, 1'b0);

        // Scenario 4: overflow of DATA_W
        start_tile(1'b0);
        send(2, 32'h7FFF_FFFF, 1'b0);
        send(2, 32'h7FFF_FFFF, 1'b1);
        exp_v = '{default: '0};
`ifdef CONVT_ACC_SAT_EN
        exp_v[2] = 32'h7FFF_FFFF;
`else
        exp_v[2] = 32'hFFFF_FFFE;
`endif
        drain("s4", 16'hFFFF, 1, 1'b0);

        // Scenario 5: reset mid-ACCUM, then a fresh tile
        start_tile(1'b0);
        send(1, 3, 1'b0);
        send(2, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_ready_in", 64'(ready_in), 64'd0);
        check("s5_valid_out", 64'(valid_out), 64'd0);
        start_tile(1'b0);
        send(4, 9, 1'b1);
        exp_v = '{default: '0};
        exp_v[4] = 32'd9;
        drain("s5", 16'hFFFF, 1, 1'b0);

        // Scenario 6: start pulses during CLEAR and DRAIN are ignored
        start_tile(1'b1);
        send(6, -4, 1'b1);
        exp_v = '{default: '0};
        exp_v[6] = 32'hFFFF_FFFC;
        drain("s6", 16'hFFFF, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/convt3d_overlap_add_acc.md
Name: convt3d_overlap_add_acc

Overview:
- Downstream stage of the grouped, strided 3D transposed-convolution datapath.
- Accepts a stream of scattered partial products, each an (output address, psum) pair, and overlap-adds them into an on-chip tile buffer.
- Once the tile's last psum is absorbed, streams the finished output voxels out in address order.
- One instance per output-channel group lane.

Parameters:
- DATA_W, 32: width of psum input and output_data (signed two's complement).
- ACC_W, 40: width of each stored accumulator word; must exceed DATA_W.
- DEPTH, 256: output voxels per tile.
- ADDR_W, 8: address width; clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a new tile. Honoured only in IDLE.
- valid_in  in  1  psum beat valid.
- ready_in  out  1  block can accept a psum beat.
- addr_in  in  ADDR_W  target output voxel.
- input_data  in  DATA_W  signed partial product.
- last_in  in  1  marks the tile's final psum beat.
- valid_out  out  1  output voxel valid.
- ready_out  in  1  consumer accepts the voxel.
- output_data  out  DATA_W  finished voxel value.
- addr_out  out  ADDR_W  voxel index of output_data.
- last_out  out  1  high with the voxel at addr DEPTH-1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: rst_n low at a clock edge forces:
  - state IDLE;
  - ready_in, valid_out, last_out, busy = 0;
  - output_data, addr_out = 0;
  - pipeline valids cleared.
  - Buffer contents are not reset. This applies mid-tile as well; partial results are discarded.
- FSM states: IDLE, CLEAR, ACCUM, FLUSH, DRAIN.
- IDLE:
  - start goes to CLEAR.
  - valid_in is ignored (ready_in = 0).
- CLEAR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle; takes exactly DEPTH cycles.
  - ready_in = 0; start is ignored.
  - Then goes to ACCUM.
- ACCUM:
  - ready_in = 1. A beat transfers when valid_in && ready_in.
  - The accumulate path is a 2-stage read-modify-write:
    - Stage A: registers addr and psum, issues the synchronous buffer read.
    - Stage B: computes sum = rdata + sign-extended psum to ACC_W, wraps modulo 2^ACC_W, writes it back.
  - Throughput: one beat per cycle.
  - Hazard forwarding: when Stage B writes address X while Stage A holds X, Stage A uses Stage B's sum, not the stale read. Back-to-back and same-address runs of any length must therefore accumulate exactly.
  - A transferred beat with last_in = 1 moves the FSM to FLUSH. ready_in drops the following cycle.
- FLUSH:
  - ready_in = 0.
  - Waits until both pipeline stages are empty, at most 2 cycles, then goes to DRAIN.
- DRAIN:
  - Reads addresses 0..DEPTH-1 in order through the 2-entry skid sub-module.
  - The first valid_out appears 2 cycles after entering DRAIN.
  - With ready_out held high, one voxel is emitted per cycle.
  - valid_out && !ready_out: output_data, addr_out and last_out must hold stable; valid_out must not drop.
  - After the handshake of the voxel with last_out, the FSM returns to IDLE on the next cycle with valid_out = 0.
- Output conversion: the ACC_W value is reduced to DATA_W per the optional feature.
- Boundaries:
  - start in any non-IDLE state is ignored.
  - A tile may contain zero hits at some addresses; those drain as 0.
  - addr_in >= DEPTH (non-power-of-2 DEPTH only) is dropped, with no write.
  - last_in on the first ACCUM beat is legal.

Optional Feature:
- Macro: CONVT_ACC_SAT_EN.
- Defined: output_data is the ACC_W value saturated to the signed DATA_W range, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: output_data is the low DATA_W bits of the accumulator (plain truncation), with no saturation logic.

Decomposition:
- Shared package convt3d_pkg holds:
  - the state enum acc_state_t (IDLE, CLEAR, ACCUM, FLUSH, DRAIN);
  - default DATA_W, ACC_W, DEPTH constants;
  - function sat_to_data (ACC_W to DATA_W saturation).
- One sub-module, convt3d_acc_skid: 2-entry skid buffer decoupling the synchronous-read buffer from ready_out backpressure in DRAIN.
- The buffer itself is an inferred single-write, single-read synchronous RAM inside the top.

Test Plan:
- Bench uses DEPTH=8, ADDR_W=3 unless stated.
- Scenario 1: start, then psums (addr,val) = (0,5),(1,7),(0,-2),(7,100) with last on (7,100), ready_out=1.
  - Required: drain 3,7,0,0,0,0,0,100; last_out with addr 7; busy falls after that handshake.
- Scenario 2: back-to-back same address, 6 consecutive beats to addr 3 with value 1.
  - Required: addr 3 drains 6, proving forwarding; all other addresses drain 0.
- Scenario 3: ready_out toggled 1,0,0,1,0,1 during DRAIN.
  - Required: no voxel lost or duplicated; output_data stable while stalled; 8 voxels in order.
- Scenario 4: two beats of 0x7FFFFFFF to addr 2.
  - With CONVT_ACC_SAT_EN: addr 2 drains 0x7FFFFFFF.
  - Without it: drains 0xFFFFFFFE.
- Scenario 5: rst_n low for 1 cycle midway through ACCUM.
  - Required: next cycle IDLE, busy=0, ready_in=0, valid_out=0.
  - A new start then clears the buffer, so a fresh tile with a single (4,9) beat drains 0,0,0,0,9,0,0,0.
- Scenario 6: start pulsed during CLEAR and during DRAIN.
  - Required: ignored; CLEAR still lasts exactly 8 cycles; drain sequence unaffected.
